string_lane_renderer: RTL and testbench



---
 rtl/gh_av_pkg.sv | 20 ++
 rtl/lane_note_store.sv | 89 ++++++++
 rtl/string_lane_renderer.sv | 138 +++++++++++++
 tb/tb_string_lane_renderer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gh_av_pkg.sv
// Shared display package for the guitar-lane video path.
// Holds the active-area geometry, the pixel word width, the RGB444
// colour constants and the note entry layout used by every lane.
package gh_av_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;
  localparam int PIXEL_W  = 13;

  localparam logic [11:0] RGB_BLACK = 12'h000;
  localparam logic [11:0] RGB_WHITE = 12'hFFF;
  localparam logic [11:0] RGB_RED   = 12'hF00;

  // One scheduled note: bottom edge row and length in rows.
  typedef struct packed {
    logic [10:0] y_bot;
    logic [7:0]  len;
  } note_t;

endpackage

// File: rtl/lane_note_store.sv
// Circular store of scheduled notes for one lane.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (control only)
//   i_push, i_len     append a note {0, i_len} at the tail when ready
//   i_pop             drop the oldest note (ignored when empty)
//   i_scroll          advance every live note by SPEED rows, saturating
//   o_entries, o_live parallel view of all slots and which are occupied
//   o_oldest          slot at the head pointer
//   o_count, o_ready  occupancy and "slot available"
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module lane_note_store
  import gh_av_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SPEED = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [7:0]                 i_len,
  input  logic                       i_pop,
  input  logic                       i_scroll,
  output note_t [DEPTH-1:0]          o_entries,
  output logic  [DEPTH-1:0]          o_live,
  output note_t                      o_oldest,
  output logic  [$clog2(DEPTH):0]    o_count,
  output logic                       o_ready
);

  localparam int PW = $clog2(DEPTH);

  note_t [DEPTH-1:0] r_mem;
  logic  [PW-1:0]    r_head;
  logic  [PW-1:0]    r_tail;
  logic  [PW:0]      r_count;
  logic              w_push;
  logic              w_pop;

  function automatic logic [10:0] sat_add(input logic [10:0] y);
    logic [11:0] s;
    s = {1'b0, y} + 12'(SPEED);
    return s[11] ? 11'h7FF : s[10:0];
  endfunction

  assign o_ready   = (r_count != (PW+1)'(DEPTH));
  assign w_push    = i_push && o_ready;
  assign w_pop     = i_pop && (r_count != '0);
  assign o_entries = r_mem;
  assign o_oldest  = r_mem[r_head];
  assign o_count   = r_count;

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    o_live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_live[i] = ({1'b0, PW'(PW'(i) - r_head)} < r_count);
    end
  end

  // The freshly pushed slot is not live yet, so a push coinciding with a
  // scroll lands at row 0 and is not advanced this frame.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_push && (PW'(i) == r_tail)) begin
        r_mem[i].y_bot <= 11'd0;
        r_mem[i].len   <= (i_len == 8'd0) ? 8'd1 : i_len;
      end else if (i_scroll && o_live[i]) begin
        r_mem[i].y_bot <= sat_add(r_mem[i].y_bot);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/string_lane_renderer.sv
// Falling-note lane for one guitar string (1024x768 @ 65 MHz).
// Scrolls stored notes once per frame, judges strums against the strike
// line, and renders a registered 13-bit pixel {own, RGB444}.
// Ports:
//   clk65, rst_n          pixel clock, asynchronous active-low reset
//   hcount, vcount        raster position (pixel appears one cycle later)
//   frame_tick, pause     per-frame scroll pulse, freeze scroll/judge
//   note_valid, note_len  spawn request / length (0 means 1)
//   note_ready            a slot is free
//   strum                 strum pulse; hit_ok / miss report the verdict
//   string_pixel          {own, colour}, zero when not owned
// Optional build macro: STRIKE_BAR_EN draws a white strike bar on rows
// HIT_Y-1..HIT_Y+1 inside the lane, underneath any note.
module string_lane_renderer
  import gh_av_pkg::*;
#(
  parameter int          LANE_X     = 64,
  parameter int          LANE_W     = 64,
  parameter logic [11:0] NOTE_COLOR = 12'hF00,
  parameter int          SPEED      = 4,
  parameter int          DEPTH      = 8,
  parameter int          HIT_Y      = 700,
  parameter int          HIT_WIN    = 16
) (
  input  logic               clk65,
  input  logic               rst_n,
  input  logic [10:0]        hcount,
  input  logic [9:0]         vcount,
  input  logic               frame_tick,
  input  logic               pause,
  input  logic               note_valid,
  input  logic [7:0]         note_len,
  output logic               note_ready,
  input  logic               strum,
  output logic               hit_ok,
  output logic               miss,
  output logic [PIXEL_W-1:0] string_pixel
);

  localparam logic signed [12:0] C_HIT = 13'(HIT_Y);
  localparam logic signed [12:0] C_WIN = 13'(HIT_WIN);

  note_t [DEPTH-1:0]       w_entries;
  logic  [DEPTH-1:0]       w_live;
  note_t                   w_old;
  logic  [10:0]            w_old_y;
  logic  [$clog2(DEPTH):0] w_count;
  logic                    w_tick;
  logic                    w_strum;
  logic                    w_in_win;
  logic                    w_esc;
  logic                    w_pop;
  logic signed [12:0]      w_diff;
  logic signed [11:0]      w_vs;
  logic                    w_in_lane;
  logic                    w_note_hit;
  logic                    w_bar;
  logic                    r_hit;
  logic                    r_miss;
  logic [PIXEL_W-1:0]      r_pixel_p1;

  lane_note_store #(.DEPTH(DEPTH), .SPEED(SPEED)) u_store (
    .clk       (clk65),
    .rst_n     (rst_n),
    .i_push    (note_valid),
    .i_len     (note_len),
    .i_pop     (w_pop),
    .i_scroll  (w_tick),
    .o_entries (w_entries),
    .o_live    (w_live),
    .o_oldest  (w_old),
    .o_count   (w_count),
    .o_ready   (note_ready)
  );

  assign w_old_y  = w_old.y_bot;
  assign w_tick   = frame_tick && !pause;
  assign w_strum  = strum && !pause;
  assign w_diff   = $signed({2'b00, w_old_y}) - C_HIT;
  assign w_in_win = (w_count != '0) && (w_diff >= -C_WIN) && (w_diff <= C_WIN);

  // A strum owns the oldest entry this cycle; any escape waits a cycle.
  assign w_esc = !pause && !strum && (w_count != '0) &&
                 ({1'b0, w_old_y} >= (12'(V_ACTIVE) + {4'b0000, w_old.len}));
  assign w_pop = (w_strum && w_in_win) || w_esc;

  always_ff @(posedge clk65 or negedge rst_n) begin
    if (!rst_n) begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
    end else begin
      r_hit  <= w_strum && w_in_win;
      r_miss <= (w_strum && !w_in_win) || w_esc;
    end
  end

  assign hit_ok = r_hit;
  assign miss   = r_miss;

  assign w_vs      = $signed({2'b00, vcount});
  assign w_in_lane = ({1'b0, hcount} >= 12'(LANE_X)) &&
                     ({1'b0, hcount} <  12'(LANE_X + LANE_W));

  // Note top is evaluated signed so notes straddling row 0 still draw.
  always_comb begin
    w_note_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_live[i] &&
          (($signed({1'b0, w_entries[i].y_bot}) - $signed({4'b0000, w_entries[i].len})) < w_vs) &&
          (w_vs <= $signed({1'b0, w_entries[i].y_bot}))) begin
        w_note_hit = 1'b1;
      end
    end
  end

`ifdef STRIKE_BAR_EN
  assign w_bar = ($signed({3'b000, vcount}) >= (C_HIT - 13'sd1)) &&
                 ($signed({3'b000, vcount}) <= (C_HIT + 13'sd1));
`else
  assign w_bar = 1'b0;
`endif

  // p0 -> p1: raster position to registered pixel word
  always_ff @(posedge clk65 or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel_p1 <= '0;
    end else if (w_in_lane && w_note_hit) begin
      r_pixel_p1 <= {1'b1, NOTE_COLOR};
    end else if (w_in_lane && w_bar) begin
      r_pixel_p1 <= {1'b1, RGB_WHITE};
    end else begin
      r_pixel_p1 <= {1'b0, RGB_BLACK};
    end
  end

  assign string_pixel = r_pixel_p1;

endmodule

// File: tb/tb_string_lane_renderer.sv
module tb_string_lane_renderer;

  logic        clk65 = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        frame_tick = 1'b0;
  logic        pause = 1'b0;
  logic        note_valid = 1'b0;
  logic [7:0]  note_len = '0;
  logic        note_ready;
  logic        strum = 1'b0;
  logic        hit_ok;
  logic        miss;
  logic [12:0] string_pixel;

  int errs = 0;
  int checks = 0;
  int n_hit = 0;
  int n_miss = 0;
  int m0;
  int h0;

`ifdef STRIKE_BAR_EN
  localparam logic [12:0] BAR_PX = 13'h1FFF;
`else
  localparam logic [12:0] BAR_PX = 13'h0000;
`endif

  string_lane_renderer dut (
    .clk65        (clk65),
    .rst_n        (rst_n),
    .hcount       (hcount),
    .vcount       (vcount),
    .frame_tick   (frame_tick),
    .pause        (pause),
    .note_valid   (note_valid),
    .note_len     (note_len),
    .note_ready   (note_ready),
    .strum        (strum),
    .hit_ok       (hit_ok),
    .miss         (miss),
    .string_pixel (string_pixel)
  );

  always #5 clk65 = ~clk65;

  always @(posedge clk65) begin
    if (hit_ok) n_hit++;
    if (miss)   n_miss++;
  end

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic [12:0] px;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk65);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
    end
    frame_tick = 1'b0;
  endtask

  task automatic push(input logic [7:0] len);
    note_valid = 1'b1;
    note_len   = len;
    cyc();
    note_valid = 1'b0;
  endtask

  task automatic pix(input string nm, input logic [10:0] h, input logic [9:0] v,
                     input logic [12:0] exp);
    hcount = h;
    vcount = v;
    cyc();
    chk(nm, 32'(string_pixel), 32'(exp));
  endtask

  task automatic do_strum();
    strum = 1'b1;
    cyc();
    strum = 1'b0;
  endtask

  initial begin
    tbl[0] = '{h: 11'd64,  v: 10'd0,   px: 13'h1F00};
    tbl[1] = '{h: 11'd64,  v: 10'd1,   px: 13'h0000};
    tbl[2] = '{h: 11'd63,  v: 10'd0,   px: 13'h0000};
    tbl[3] = '{h: 11'd127, v: 10'd0,   px: 13'h1F00};
    tbl[4] = '{h: 11'd128, v: 10'd0,   px: 13'h0000};
    tbl[5] = '{h: 11'd100, v: 10'd0,   px: 13'h1F00};
    tbl[6] = '{h: 11'd64,  v: 10'd700, px: BAR_PX};
    tbl[7] = '{h: 11'd200, v: 10'd700, px: 13'h0000};

    // Reset state
    repeat (3) cyc();
    chk("rst_pixel", 32'(string_pixel), 32'h0);
    chk("rst_ready", 32'(note_ready), 32'h1);
    chk("rst_hit", 32'(hit_ok), 32'h0);
    chk("rst_miss", 32'(miss), 32'h0);
    chk("rst_count", 32'(dut.w_count), 32'h0);
    rst_n = 1'b1;
    cyc();

    // One note of length 20 sitting at row 0
    push(8'd20);
    for (int i = 0; i < 8; i++) pix($sformatf("raster%0d", i), tbl[i].h, tbl[i].v, tbl[i].px);

    ticks(1);
    chk("y_after1", 32'(dut.w_old_y), 32'd4);
    pix("px_64_4", 11'd64, 10'd4, 13'h1F00);
    pix("px_64_5", 11'd64, 10'd5, 13'h0000);

    ticks(174);
    chk("y_700", 32'(dut.w_old_y), 32'd700);
    pix("px_700", 11'd64, 10'd700, 13'h1F00);
    pix("px_680", 11'd64, 10'd680, BAR_PX == 13'h0 ? 13'h0 : 13'h0);
    pix("px_681", 11'd64, 10'd681, 13'h1F00);

    do_strum();
    chk("hit_pulse", 32'(hit_ok), 32'h1);
    chk("hit_nomiss", 32'(miss), 32'h0);
    chk("hit_count", 32'(dut.w_count), 32'h0);
    cyc();
    chk("hit_one_cycle", 32'(hit_ok), 32'h0);
    pix("px_after_hit", 11'd64, 10'd700, BAR_PX);

    // Early strum misses and leaves the note alone
    push(8'd20);
    ticks(150);
    do_strum();
    chk("early_miss", 32'(miss), 32'h1);
    chk("early_nohit", 32'(hit_ok), 32'h0);
    chk("early_y", 32'(dut.w_old_y), 32'd600);
    chk("early_count", 32'(dut.w_count), 32'h1);
    cyc();
    chk("miss_one_cycle", 32'(miss), 32'h0);
    ticks(21);
    do_strum();
    chk("win_low_hit", 32'(hit_ok), 32'h1);
    chk("win_low_count", 32'(dut.w_count), 32'h0);
    push(8'd20);
    ticks(179);
    do_strum();
    chk("win_high_hit", 32'(hit_ok), 32'h1);

    // Strum with nothing stored
    cyc();
    do_strum();
    chk("empty_miss", 32'(miss), 32'h1);
    chk("empty_nohit", 32'(hit_ok), 32'h0);

    // Fill the store
    for (int i = 0; i < 8; i++) push(8'd5);
    chk("full_ready", 32'(note_ready), 32'h0);
    chk("full_count", 32'(dut.w_count), 32'd8);
    push(8'd5);
    chk("ninth_ignored", 32'(dut.w_count), 32'd8);
    ticks(175);
    do_strum();
    chk("full_hit", 32'(hit_ok), 32'h1);
    chk("full_hit_count", 32'(dut.w_count), 32'd7);
    note_valid = 1'b1;
    note_len   = 8'd5;
    strum      = 1'b1;
    cyc();
    note_valid = 1'b0;
    strum      = 1'b0;
    chk("push_pop_hit", 32'(hit_ok), 32'h1);
    chk("push_pop_count", 32'(dut.w_count), 32'd7);

    // Asynchronous reset in the middle of a frame
    pix("pre_rst_px", 11'd64, 10'd700, 13'h1F00);
    #2 rst_n = 1'b0;
    #1;
    chk("async_px", 32'(string_pixel), 32'h0);
    chk("async_count", 32'(dut.w_count), 32'h0);
    chk("async_ready", 32'(note_ready), 32'h1);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Escape without strums
    m0 = n_miss;
    push(8'd10);
    ticks(194);
    cyc();
    cyc();
    chk("esc_y776", 32'(dut.w_old_y), 32'd776);
    chk("esc_none_yet", 32'(n_miss - m0), 32'd0);
    ticks(1);
    repeat (4) cyc();
    chk("esc_count", 32'(dut.w_count), 32'h0);
    chk("esc_once", 32'(n_miss - m0), 32'd1);

    // Pause freezes scroll and judging but accepts pushes
    push(8'd20);
    ticks(10);
    repeat (2) cyc();
    m0 = n_miss;
    h0 = n_hit;
    pause = 1'b1;
    ticks(10);
    do_strum();
    push(8'd20);
    repeat (3) cyc();
    chk("pause_y", 32'(dut.w_old_y), 32'd40);
    chk("pause_count", 32'(dut.w_count), 32'd2);
    chk("pause_nomiss", 32'(n_miss - m0), 32'd0);
    chk("pause_nohit", 32'(n_hit - h0), 32'd0);
    pause = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
